// File: rtl/key_schedule_pkg.sv
// Shared definitions for the Anubis-128 key schedule: FSM states, S-box,
// GF(2^8) arithmetic, round constants and diffusion coefficients.
package key_schedule_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAMMA,
        THETA,
        SIGMA,
        STORE,
        SERVE
    } state_t;

    localparam int NUM_ROUNDS = 12;
    localparam int NUM_KEYS   = NUM_ROUNDS + 1;

    // 4-bit mini-boxes (entry 0 in the low nibble) from which the 8-bit S-box is built
    localparam logic [63:0] E_BOX    = 64'h052A_478E_3F6D_C9B1;
    localparam logic [63:0] EINV_BOX = 64'h6843_1C29_A5EB_7D0F;
    localparam logic [63:0] R_BOX    = 64'h0152_A836_F94E_DBC7;

    // Hadamard row had(01,02,04,06): theta coefficient for (k,j) is THETA_ROW[k^j]
    localparam logic [3:0][7:0] THETA_ROW = {8'h06, 8'h04, 8'h02, 8'h01};

    // Vandermonde rows: OMEGA_COEF[i][k] = x_k^i with x = {01,02,06,08}
    localparam logic [3:0][3:0][7:0] OMEGA_COEF = {
        {8'h3A, 8'h78, 8'h08, 8'h01},
        {8'h40, 8'h14, 8'h04, 8'h01},
        {8'h08, 8'h06, 8'h02, 8'h01},
        {8'h01, 8'h01, 8'h01, 8'h01}
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a, b, t;
        a = E_BOX[{x[7:4], 2'b00} +: 4];
        b = EINV_BOX[{x[3:0], 2'b00} +: 4];
        t = R_BOX[{a ^ b, 2'b00} +: 4];
        return {E_BOX[{a ^ t, 2'b00} +: 4], EINV_BOX[{b ^ t, 2'b00} +: 4]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] m, input int i, input int j);
        return m[127-8*(4*i+j) -: 8];
    endfunction

    // Column j rotated down by j rows
    function automatic logic [127:0] pi_perm(input logic [127:0] a);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                b[127-8*(4*i+j) -: 8] = get_byte(a, (i - j + 4) % 4, j);
        return b;
    endfunction

    function automatic logic [NUM_ROUNDS-1:0][31:0] build_round_consts();
        logic [NUM_ROUNDS-1:0][31:0] rc;
        rc = '0;
        for (int r = 0; r < NUM_ROUNDS; r++)
            for (int j = 0; j < 4; j++)
                rc[r][31-8*j -: 8] = sbox(8'(4*r + j));
        return rc;
    endfunction

    // ROUND_CONST[r] is row 0 of c^(r+1)
    localparam logic [NUM_ROUNDS-1:0][31:0] ROUND_CONST = build_round_consts();

endpackage

// File: rtl/gamma.sv
// Byte-wise S-box substitution over a 128-bit state; purely combinational.
module gamma
    import key_schedule_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar n = 0; n < 16; n++) begin : g_byte
        assign dout[8*n +: 8] = sbox(din[8*n +: 8]);
    end

endmodule

// File: rtl/key_extract.sv
// Round-key extraction omega(gamma(K)): S-box layer then Vandermonde multiply.
module key_extract
    import key_schedule_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    logic [127:0] sub;
    logic [7:0]   acc;

    gamma u_gamma (
        .din  (din),
        .dout (sub)
    );

    always_comb begin
        dout = '0;
        acc  = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(OMEGA_COEF[2'(i)][2'(k)], get_byte(sub, k, j));
                dout[127-8*(4*i+j) -: 8] = acc;
            end
        end
    end

endmodule

// File: rtl/theta.sv
// Column mixing by the Hadamard matrix had(01,02,04,06); output is registered,
// giving one cycle of latency.
module theta
    import key_schedule_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] din,
    output logic [127:0] dout
);

    logic [127:0] mix;
    logic [7:0]   acc;

    always_comb begin
        mix = '0;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(get_byte(din, i, k), THETA_ROW[2'(k ^ j)]);
                mix[127-8*(4*i+j) -: 8] = acc;
            end
        end
    end

    always_ff @(posedge clk)
        dout <= mix;

endmodule

// File: rtl/key_schedule.sv
// Anubis-128 key schedule: expands the cipher key into 13 round keys, then
// serves them one at a time under consumer handshake.
module key_schedule
    import key_schedule_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         key_next,
    output logic [127:0] round_key,
    output logic [3:0]   key_index,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [127:0] k_reg;
    logic [127:0] pg_reg;
    logic [3:0]   r;
    logic [127:0] key_buf [NUM_KEYS];
    logic [127:0] gamma_out;
    logic [127:0] theta_out;
    logic [127:0] extract_out;

    gamma u_gamma (
        .din  (k_reg),
        .dout (gamma_out)
    );

    theta u_theta (
        .clk  (clk),
        .din  (pg_reg),
        .dout (theta_out)
    );

    key_extract u_extract (
        .din  (k_reg),
        .dout (extract_out)
    );

    // The cipher key is captured on the accepting edge so LOAD extracts from a stable K
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r         <= '0;
            key_index <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg <= cipher_key;
                        r     <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    key_buf[0] <= extract_out;
                    state      <= GAMMA;
                end
                GAMMA: begin
                    pg_reg <= pi_perm(gamma_out);
                    state  <= THETA;
                end
                THETA: begin
                    state <= SIGMA;
                end
                SIGMA: begin
                    k_reg <= theta_out ^ {ROUND_CONST[r], 96'b0};
                    r     <= r + 4'd1;
                    state <= STORE;
                end
                STORE: begin
                    key_buf[r] <= extract_out;
                    if (r < 4'(NUM_ROUNDS)) begin
                        state <= GAMMA;
                    end else begin
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        key_index <= '0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (key_next) begin
                        if (key_index == 4'(NUM_ROUNDS)) begin
                            key_valid <= 1'b0;
                            key_index <= '0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            key_index <= key_index + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign round_key = key_valid ? key_buf[key_index] : '0;

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high; sampled on posedge clk only.
REQ-003 start  input  1  one-cycle pulse; begin key expansion of cipher_key; honoured only in IDLE.
REQ-004 cipher_key  input  128  Anubis 128-bit key (N=4), byte-matrix row-major, byte 0 = bits [127:120].
REQ-005 key_next  input  1  consumer acknowledges the presented round key; advance to next index.
REQ-006 round_key  output  128  round key K^key_index (extracted form), valid when key_valid=1.
REQ-007 key_index  output  4  index 0..12 of the round key on round_key.
REQ-008 key_valid  output  1  round_key/key_index valid.
REQ-009 busy  output  1  high while expanding (states LOAD..STORE).
REQ-010 done  output  1  one-cycle pulse after key 12 is acknowledged.

Function
REQ-011 States SHALL be IDLE, LOAD, GAMMA, THETA, SIGMA, STORE, SERVE.
- IDLE -> LOAD when start=1.
- LOAD -> GAMMA.
- GAMMA -> THETA -> SIGMA -> STORE.
- STORE -> GAMMA if r<12, else -> SERVE.
- SERVE -> IDLE when key_next=1 and key_index=12.
REQ-012 LOAD SHALL latch cipher_key into evolving key register K, set r=0, and write omega(gamma(K^0)) into buffer entry 0.
REQ-013 GAMMA SHALL register pi(gamma(K)).
- gamma = byte-wise S-box.
- pi: column j rotated down by j rows, b[i][j] = a[(i-j) mod 4][j].
REQ-014 THETA SHALL wait one cycle for the registered theta instance (theta has one-cycle latency) and capture its output.
REQ-015 SIGMA SHALL set K <= theta_out XOR c^(r+1) and increment r.
- c^r row 0 = S-box bytes S[4(r-1)+j], j=0..3; rows 1..3 zero.
REQ-016 STORE SHALL write omega(gamma(K)) into buffer entry r.
- omega = 4x4 Vandermonde multiply over GF(2^8), polynomial 0x11D.
REQ-017 key_valid SHALL rise exactly 49 posedges after the edge that accepted start, with key_index=0; timing is 1 (LOAD) + 12 x 4.
REQ-018 In SERVE, key_valid=1 and round_key=buffer[key_index].
- key_next=1 with key_index<12: key_index increments on that edge, new key visible next cycle.
REQ-019 key_next=1 with key_index=12 SHALL drop key_valid, pulse done for one cycle, and return to IDLE.
REQ-020 key_next outside SERVE SHALL be ignored.
REQ-021 start outside IDLE (busy or SERVE) SHALL be ignored; cipher_key is sampled only at the accepting edge.
REQ-022 key_index SHALL never exceed 12; no wrap to 13..15.
REQ-023 start and key_next asserted together SHALL obey the current state only (each ignored where REQ-020/021 apply).

Reset
REQ-024 On reset=1 at a posedge, regardless of state:
- state=IDLE; key_valid=0, busy=0, done=0.
- key_index=0; round_key=0; r=0.
- K and buffer contents are don't-care; they are not readable until regenerated.
REQ-025 Reset mid-expansion or mid-SERVE SHALL abort; the next start SHALL regenerate all 13 keys from scratch.

Structure
REQ-026 A shared package SHALL hold:
- state encodings;
- NUM_ROUNDS=12;
- the 12 precomputed 32-bit round constants;
- the omega Vandermonde coefficients.
REQ-027 The existing gamma and theta modules SHALL be instantiated unchanged.
REQ-028 Sub-module key_extract (combinational gamma + omega) SHALL be instantiated once and shared by LOAD and STORE.
REQ-029 Buffer: 13 x 128-bit registers, written only in LOAD/STORE.

Verification
REQ-030 cipher_key=0, start at edge 10 -> busy edges 11..59, key_valid at edge 59 with key_index=0; all 13 keys match the golden software model.
REQ-031 Key 000102...0F, key_next every cycle -> key_index 0..12 in 13 consecutive cycles, done pulse once, key_valid low after.
REQ-032 Key all FF, key_next held low 100 cycles in SERVE -> key_index stays 0, round_key stable.
REQ-033 start pulses at edges 20 and 40 during expansion -> ignored; key_valid still at edge 49 after the first start.
REQ-034 reset at edge 30 mid-expansion, new start -> outputs zero on the reset edge; restart yields correct keys for the new key.
REQ-035 key_next asserted during expansion -> no effect; first SERVE key_index=0.
